// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and default frame/oversample constants.
//   STATE_IDLE/START/DATA/STOP - 2-bit FSM encodings used by both rx and tx
//   DEFAULT_DATA_BITS          - data bits per frame
//   DEFAULT_OVERSAMPLE         - enb ticks per bit period
package uart_pkg;
    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_START = 2'd1,
        STATE_DATA  = 2'd2,
        STATE_STOP  = 2'd3
    } state_t;
    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous level, resets to 1.
//   clk - destination clock
//   rst - asynchronous active-low reset
//   d   - asynchronous input
//   q   - synchronized output, two clk of latency
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with oversampling tick, ready/clear handshake and error flags.
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   rx        - serial input, idles high, asynchronous to clk
//   enb       - oversample strobe, OVERSAMPLE per bit period
//   rdy_clr   - consumer acknowledge, clears rdy and overrun
//   data_out  - last good byte received
//   rdy       - a byte is valid on data_out
//   frame_err - last frame had a low stop bit
//   overrun   - a byte completed while rdy was still set
//   rx_busy   - receiver is inside a frame
module uart_rx import uart_pkg::*; #(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 enb,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign rx_busy = (state != STATE_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= STATE_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_out  <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Acknowledge runs every clk; a completing good stop below overrides it.
            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
            if (enb) begin
                case (state)
                    STATE_IDLE: begin
                        if (!rx_s) begin
                            state <= STATE_START;
                            cnt   <= '0;
                        end
                    end
                    STATE_START: begin
                        if (cnt == CNT_HALF) begin
                            // A start bit that is high again at mid-bit is a glitch.
                            state   <= rx_s ? STATE_IDLE : STATE_DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STATE_DATA: begin
                        if (cnt == CNT_LAST) begin
                            shift[bit_idx] <= rx_s;
                            cnt            <= '0;
                            if (bit_idx == BIT_LAST) state <= STATE_STOP;
                            else bit_idx <= bit_idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STATE_STOP: begin
                        if (cnt == CNT_LAST) begin
                            state <= STATE_IDLE;
                            cnt   <= '0;
                            if (rx_s) begin
                                data_out  <= shift;
                                rdy       <= 1'b1;
                                frame_err <= 1'b0;
                                overrun   <= rdy && !rdy_clr;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= STATE_IDLE;
                endcase
            end
        end
    end
endmodule
